mshr_file_ctrl: RTL and testbench
=================================

// Module: mshr_file_ctrl
// PURPOSE
//  Front-end controller for the bank of BoomMSHR instances in the non-blocking D$. Steers each miss
//  to a free MSHR (primary) or to the MSHR already holding that line (secondary), else nacks it.
//  Round-robin arbitrates the MSHRs' shared meta-write port. Sits between the miss pipe and MSHRs.
// PARAMETERS
//  N_MSHRS   4   number of MSHRs; power of two, >=2
//  IDX_W     6   set-index width
//  TAG_W     20  tag width
// PORTS
//  clock          in   1              clock
//  reset          in   1              synchronous, active-low reset
//  i_req_valid    in   1              miss request from pipe
//  o_req_ready    out  1              request consumed (accepted or nacked) this cycle
//  i_req_idx      in   IDX_W          set index of miss
//  i_req_tag      in   TAG_W          tag of miss
//  o_nack         out  1              valid only with i_req_valid&o_req_ready; pipe must replay
//  o_pri_val      out  N_MSHRS        one-hot primary strobe to MSHR i
//  i_pri_rdy      in   N_MSHRS        MSHR i idle (s_invalid)
//  o_sec_val      out  N_MSHRS        one-hot secondary strobe to MSHR i
//  i_sec_rdy      in   N_MSHRS        MSHR i can merge (rpq not full, state allows)
//  i_mshr_vld     in   N_MSHRS        MSHR i holds a line (its idx/tag valid)
//  i_mshr_idx     in   N_MSHRS*IDX_W  per-MSHR set index, MSHR i at [i*IDX_W +: IDX_W]
//  i_mshr_tag     in   N_MSHRS*TAG_W  per-MSHR tag, same packing
//  o_alloc_id     out  $clog2(N)      MSHR id chosen this cycle (don't-care when no strobe)
//  i_mw_req       in   N_MSHRS        meta-write requests from MSHRs
//  o_mw_grant     out  N_MSHRS        one-hot meta-write grant
//  i_mw_ready     in   1              meta-write port accepts
//  o_busy_cnt     out  $clog2(N)+1    MSHRs with i_mshr_vld set, registered
// BEHAVIOUR
//  Reset (reset==0 at posedge): rr_alloc=0, rr_mw=0, shadow_vld=0, mw_lock=0, o_busy_cnt=0.
//   All strobe/grant outputs must be 0 during and in the first cycle after reset.
//  Match: hit_i = i_mshr_vld[i] & idx_i==i_req_idx; full_i = hit_i & tag_i==i_req_tag.
//   Shadow: new_alloc = i_req_valid & o_req_ready & !o_nack & |o_pri_val; on new_alloc register
//   {id, idx, tag}, shadow_vld=1 for 1 cycle. That covers the MSHR's 1-cycle idx/tag latency;
//   shadow entry is OR'ed into hit/full.
//  Decision (combinational, 0-cycle latency, priority order):
//   1. any full hit: route to it as secondary; if i_sec_rdy of it -> o_sec_val one-hot,
//      else nack. A full hit on shadow only means MSHR in s_refill_req; accept if i_sec_rdy.
//   2. any idx hit with different tag (set conflict) -> nack.
//   3. else first i_pri_rdy at/after rr_alloc (wrap mod N) -> o_pri_val; none free -> nack.
//  o_req_ready = 1 always (every request resolves same cycle); strobes only when i_req_valid.
//  rr_alloc <= chosen+1 (mod N) on each primary allocation; unchanged otherwise.
//  Never more than one bit set across o_pri_val|o_sec_val; never both o_nack and a strobe.
//  Meta-write arbiter: when !mw_lock, grant first i_mw_req at/after rr_mw. If i_mw_ready same
//   cycle: done, rr_mw <= winner+1. Else mw_lock=1 and grant holds on the same winner until
//   i_mw_ready. A requester dropping i_mw_req while locked is a protocol error (assert);
//   the lock still clears.
//  o_busy_cnt <= popcount(i_mshr_vld) each cycle.
//  Reset mid-operation: all state cleared; in-flight grant dropped (MSHRs are reset together).
// STRUCTURE
//  mshr_pkg: MSHR_ID_W, typedef mshr_addr_t {idx,tag}, function rr_pick(req,ptr) one-hot.
//  Sub-module rr_arbiter (N-way, lock-on-not-ready) for meta-write; allocation reuses rr_pick.
//  Rest flat: match logic, shadow register, decision mux.
// TESTING
//  All MSHRs idle, req idx=5 tag=0x100 -> o_pri_val=0001, id=0; next cycle same req -> shadow hit,
//   o_sec_val=0001 (i_sec_rdy[0]=1), no double primary.
//  MSHR1 vld idx=5 tag=0x100, req idx=5 tag=0x200 -> o_nack=1, no strobes.
//  MSHR2 full hit, i_sec_rdy[2]=0 -> o_nack=1; i_sec_rdy[2]=1 -> o_sec_val=0100.
//  rr_alloc=3, all i_pri_rdy=1, 3 new lines -> ids 3,0,1 (wrap).
//  i_mw_req=1010, i_mw_ready=0 for 3 cycles -> o_mw_grant=0010 held; ready=1 -> next grant 1000.
//  Assert reset low mid-lock -> next cycle o_mw_grant=0, o_busy_cnt=0, rr pointers 0.

Source files
------------

// File: rtl/mshr_file_ctrl_pkg.sv
// Shared types, sizing constants and helpers for the MSHR file controller.
// MSHR_N / IDX_BITS / TAG_BITS are the default geometry of the miss-handling
// bank. mshr_addr_t is the {idx, tag} pair an MSHR tracks. rr_pick returns a
// one-hot grant for the first requester at or after a pointer (wrapping).
// oh_to_idx converts a one-hot vector to its bit position.
package mshr_file_ctrl_pkg;

  localparam int MSHR_N    = 4;
  localparam int IDX_BITS  = 6;
  localparam int TAG_BITS  = 20;
  localparam int MSHR_ID_W = $clog2(MSHR_N);

  typedef struct packed {
    logic [IDX_BITS-1:0] idx;
    logic [TAG_BITS-1:0] tag;
  } mshr_addr_t;

  // First set bit of req at or after ptr, wrapping modulo n (n a power of two).
  function automatic logic [31:0] rr_pick(input logic [31:0] req,
                                          input int unsigned ptr,
                                          input int unsigned n);
    logic [31:0] grant;
    logic        found;
    logic [4:0]  j;
    grant = 32'd0;
    found = 1'b0;
    for (int k = 0; k < 32; k++) begin
      j = 5'((ptr + 32'(k)) & (n - 32'd1));
      if ((32'(k) < n) && !found && req[j]) begin
        grant[j] = 1'b1;
        found    = 1'b1;
      end else begin
        grant = grant;
      end
    end
    return grant;
  endfunction

  // Position of the lowest set bit; 0 when nothing is set.
  function automatic int unsigned oh_to_idx(input logic [31:0] oh);
    int unsigned pos;
    pos = 32'd0;
    for (int k = 31; k >= 0; k--) begin
      if (oh[k[4:0]]) begin
        pos = 32'(k);
      end else begin
        pos = pos;
      end
    end
    return pos;
  endfunction

endpackage

// File: rtl/mshr_file_ctrl_chk.sv
// Protocol and invariant checker for the MSHR file controller (simulation
// only; synthesis ignores the assertions). Ports mirror the controller's
// request strobes and meta-write arbiter state.
module mshr_file_ctrl_chk #(
  parameter int N = 4
) (
  input logic         clock,
  input logic         reset,
  input logic [N-1:0] pri_val,
  input logic [N-1:0] sec_val,
  input logic         nack,
  input logic [N-1:0] mw_req,
  input logic [N-1:0] mw_grant,
  input logic         mw_lock,
  input logic [N-1:0] mw_winner
);

  a_strobe_onehot: assert property (@(posedge clock) disable iff (!reset)
    $onehot0(pri_val | sec_val))
    else $error("more than one MSHR strobe set");

  a_nack_excl: assert property (@(posedge clock) disable iff (!reset)
    !(nack && (|(pri_val | sec_val))))
    else $error("nack together with a strobe");

  a_grant_onehot: assert property (@(posedge clock) disable iff (!reset)
    $onehot0(mw_grant))
    else $error("meta-write grant not one-hot");

  a_mw_hold: assert property (@(posedge clock) disable iff (!reset)
    mw_lock |-> (|(mw_winner & mw_req)))
    else $error("meta-write requester dropped its request while locked");

endmodule

// File: rtl/mshr_file_ctrl_rr_arbiter.sv
// N-way round-robin arbiter that locks onto its winner until the shared port
// accepts. Ports:
//   clock, reset  - clock, synchronous active-low reset
//   req           - request vector (already gated by the parent)
//   ready         - shared port accepts this cycle
//   grant         - one-hot grant (combinational)
//   lock, winner  - lock state and held winner, exported for checking
module mshr_file_ctrl_rr_arbiter
  import mshr_file_ctrl_pkg::*;
#(
  parameter int N = MSHR_N
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [N-1:0] req,
  input  logic         ready,
  output logic [N-1:0] grant,
  output logic         lock,
  output logic [N-1:0] winner
);

  localparam int PW = $clog2(N);

  logic [PW-1:0] ptr_r;
  logic          lock_r;
  logic [N-1:0]  winner_r;
  logic [N-1:0]  grant_s;
  logic [N-1:0]  pick_s;

  // Grant selection: a held winner keeps the port, otherwise round-robin pick.
  always_comb begin
    grant_s = {N{1'b0}};
    pick_s  = N'(rr_pick(32'(req), 32'(ptr_r), 32'(N)));
    if (lock_r) begin
      // A winner that withdraws loses the grant; the lock then clears below.
      grant_s = winner_r & req;
    end else begin
      grant_s = pick_s;
    end
  end

  // Pointer / lock state update.
  always_ff @(posedge clock) begin
    if (!reset) begin
      ptr_r    <= {PW{1'b0}};
      lock_r   <= 1'b0;
      winner_r <= {N{1'b0}};
    end else if (lock_r) begin
      if (!(|(winner_r & req))) begin
        lock_r <= 1'b0;
      end else if (ready) begin
        lock_r <= 1'b0;
        ptr_r  <= PW'(oh_to_idx(32'(winner_r))) + PW'(1);
      end else begin
        lock_r <= 1'b1;
      end
    end else if (|grant_s) begin
      if (ready) begin
        ptr_r <= PW'(oh_to_idx(32'(grant_s))) + PW'(1);
      end else begin
        lock_r   <= 1'b1;
        winner_r <= grant_s;
      end
    end else begin
      lock_r <= 1'b0;
    end
  end

  assign grant  = grant_s;
  assign lock   = lock_r;
  assign winner = winner_r;

endmodule

// File: rtl/mshr_file_ctrl.sv
// Front-end controller for the MSHR bank of the non-blocking data cache.
// Each miss is steered to the MSHR already holding its line (secondary),
// nacked on a set conflict or a full merge queue, or given a free MSHR in
// round-robin order (primary). Also arbitrates the MSHRs' meta-write port.
// Ports:
//   clock, reset            - clock, synchronous active-low reset
//   i_req_*/o_req_ready     - miss request from the pipe, always consumed
//   o_nack                  - request must be replayed
//   o_pri_val/i_pri_rdy     - primary allocate strobe / MSHR idle
//   o_sec_val/i_sec_rdy     - secondary merge strobe / MSHR can merge
//   i_mshr_vld/idx/tag      - per-MSHR held line, MSHR i at [i*W +: W]
//   o_alloc_id              - MSHR chosen this cycle
//   i_mw_req/o_mw_grant/i_mw_ready - meta-write arbitration
//   o_busy_cnt              - registered count of MSHRs holding a line
module mshr_file_ctrl
  import mshr_file_ctrl_pkg::*;
#(
  parameter int N_MSHRS = MSHR_N,
  parameter int IDX_W   = IDX_BITS,
  parameter int TAG_W   = TAG_BITS
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       i_req_valid,
  output logic                       o_req_ready,
  input  logic [IDX_W-1:0]           i_req_idx,
  input  logic [TAG_W-1:0]           i_req_tag,
  output logic                       o_nack,
  output logic [N_MSHRS-1:0]         o_pri_val,
  input  logic [N_MSHRS-1:0]         i_pri_rdy,
  output logic [N_MSHRS-1:0]         o_sec_val,
  input  logic [N_MSHRS-1:0]         i_sec_rdy,
  input  logic [N_MSHRS-1:0]         i_mshr_vld,
  input  logic [N_MSHRS*IDX_W-1:0]   i_mshr_idx,
  input  logic [N_MSHRS*TAG_W-1:0]   i_mshr_tag,
  output logic [$clog2(N_MSHRS)-1:0] o_alloc_id,
  input  logic [N_MSHRS-1:0]         i_mw_req,
  output logic [N_MSHRS-1:0]         o_mw_grant,
  input  logic                       i_mw_ready,
  output logic [$clog2(N_MSHRS):0]   o_busy_cnt
);

  localparam int ID_W = $clog2(N_MSHRS);

  logic                 out_en_r;
  logic                 live_s;
  logic [ID_W-1:0]      rr_alloc_r;
  logic                 shadow_vld_r;
  logic [ID_W-1:0]      shadow_id_r;
  mshr_addr_t           shadow_addr_r;
  logic [ID_W:0]        busy_cnt_r;

  logic [N_MSHRS-1:0]   hit_s;
  logic [N_MSHRS-1:0]   full_s;
  logic [N_MSHRS-1:0]   full_oh_s;
  logic [N_MSHRS-1:0]   free_oh_s;
  logic                 sh_hit_s;
  logic                 sh_full_s;

  logic [N_MSHRS-1:0]   pri_val_s;
  logic [N_MSHRS-1:0]   sec_val_s;
  logic                 nack_s;
  logic [ID_W-1:0]      alloc_id_s;
  logic                 new_alloc_s;

  logic [N_MSHRS-1:0]   mw_req_s;
  logic [N_MSHRS-1:0]   mw_grant_s;
  logic                 mw_lock_s;
  logic [N_MSHRS-1:0]   mw_winner_s;

  // Strobes and grants stay off while reset is low and for one cycle after.
  assign live_s = reset & out_en_r;

  // Address match against the MSHRs and the one-cycle shadow of the last
  // primary allocation (whose MSHR does not yet show its idx/tag).
  always_comb begin
    hit_s     = {N_MSHRS{1'b0}};
    full_s    = {N_MSHRS{1'b0}};
    sh_hit_s  = shadow_vld_r && (shadow_addr_r.idx == i_req_idx);
    sh_full_s = sh_hit_s && (shadow_addr_r.tag == i_req_tag);
    for (int i = 0; i < N_MSHRS; i++) begin
      hit_s[i]  = (i_mshr_vld[i] && (i_mshr_idx[i*IDX_W +: IDX_W] == i_req_idx))
                  || (sh_hit_s && (shadow_id_r == ID_W'(i)));
      full_s[i] = (i_mshr_vld[i] && (i_mshr_idx[i*IDX_W +: IDX_W] == i_req_idx)
                   && (i_mshr_tag[i*TAG_W +: TAG_W] == i_req_tag))
                  || (sh_full_s && (shadow_id_r == ID_W'(i)));
    end
    full_oh_s = N_MSHRS'(rr_pick(32'(full_s), 32'd0, 32'(N_MSHRS)));
    free_oh_s = N_MSHRS'(rr_pick(32'(i_pri_rdy), 32'(rr_alloc_r), 32'(N_MSHRS)));
  end

  // Request decision: merge, conflict nack, primary allocate, or nack.
  always_comb begin
    pri_val_s   = {N_MSHRS{1'b0}};
    sec_val_s   = {N_MSHRS{1'b0}};
    nack_s      = 1'b0;
    alloc_id_s  = {ID_W{1'b0}};
    new_alloc_s = 1'b0;
    if (!i_req_valid) begin
      nack_s = 1'b0;
    end else if (!live_s) begin
      nack_s = 1'b1;
    end else if (|full_s) begin
      alloc_id_s = ID_W'(oh_to_idx(32'(full_oh_s)));
      if (|(full_oh_s & i_sec_rdy)) begin
        sec_val_s = full_oh_s;
      end else begin
        nack_s = 1'b1;
      end
    end else if (|hit_s) begin
      nack_s = 1'b1;
    end else if (|free_oh_s) begin
      pri_val_s   = free_oh_s;
      alloc_id_s  = ID_W'(oh_to_idx(32'(free_oh_s)));
      new_alloc_s = 1'b1;
    end else begin
      nack_s = 1'b1;
    end
  end

  // Output enable, allocation pointer and shadow of the last primary.
  always_ff @(posedge clock) begin
    if (!reset) begin
      out_en_r      <= 1'b0;
      rr_alloc_r    <= {ID_W{1'b0}};
      shadow_vld_r  <= 1'b0;
      shadow_id_r   <= {ID_W{1'b0}};
      shadow_addr_r <= '0;
    end else begin
      out_en_r     <= 1'b1;
      shadow_vld_r <= new_alloc_s;
      if (new_alloc_s) begin
        rr_alloc_r    <= alloc_id_s + ID_W'(1);
        shadow_id_r   <= alloc_id_s;
        shadow_addr_r <= '{idx: i_req_idx, tag: i_req_tag};
      end else begin
        rr_alloc_r <= rr_alloc_r;
      end
    end
  end

  // Registered occupancy count.
  always_ff @(posedge clock) begin
    if (!reset) begin
      busy_cnt_r <= {(ID_W+1){1'b0}};
    end else begin
      busy_cnt_r <= (ID_W+1)'($countones(i_mshr_vld));
    end
  end

  assign mw_req_s = i_mw_req & {N_MSHRS{live_s}};

  mshr_file_ctrl_rr_arbiter #(.N(N_MSHRS)) u_mw_arb (
    .clock  (clock),
    .reset  (reset),
    .req    (mw_req_s),
    .ready  (i_mw_ready),
    .grant  (mw_grant_s),
    .lock   (mw_lock_s),
    .winner (mw_winner_s)
  );

  mshr_file_ctrl_chk #(.N(N_MSHRS)) u_chk (
    .clock     (clock),
    .reset     (reset),
    .pri_val   (pri_val_s),
    .sec_val   (sec_val_s),
    .nack      (nack_s),
    .mw_req    (mw_req_s),
    .mw_grant  (mw_grant_s),
    .mw_lock   (mw_lock_s),
    .mw_winner (mw_winner_s)
  );

  assign o_req_ready = 1'b1;
  assign o_nack      = nack_s;
  assign o_pri_val   = pri_val_s;
  assign o_sec_val   = sec_val_s;
  assign o_alloc_id  = alloc_id_s;
  assign o_mw_grant  = mw_grant_s;
  assign o_busy_cnt  = busy_cnt_r;

endmodule

// File: tb/tb_mshr_file_ctrl.sv
module tb_mshr_file_ctrl;

  logic        clock = 1'b0;
  logic        reset;
  logic        i_req_valid;
  logic        o_req_ready;
  logic [5:0]  i_req_idx;
  logic [19:0] i_req_tag;
  logic        o_nack;
  logic [3:0]  o_pri_val, i_pri_rdy, o_sec_val, i_sec_rdy, i_mshr_vld;
  logic [23:0] i_mshr_idx;
  logic [79:0] i_mshr_tag;
  logic [1:0]  o_alloc_id;
  logic [3:0]  i_mw_req, o_mw_grant;
  logic        i_mw_ready;
  logic [2:0]  o_busy_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  mshr_file_ctrl dut (
    .clock(clock), .reset(reset),
    .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
    .i_req_idx(i_req_idx), .i_req_tag(i_req_tag), .o_nack(o_nack),
    .o_pri_val(o_pri_val), .i_pri_rdy(i_pri_rdy),
    .o_sec_val(o_sec_val), .i_sec_rdy(i_sec_rdy),
    .i_mshr_vld(i_mshr_vld), .i_mshr_idx(i_mshr_idx), .i_mshr_tag(i_mshr_tag),
    .o_alloc_id(o_alloc_id),
    .i_mw_req(i_mw_req), .o_mw_grant(o_mw_grant), .i_mw_ready(i_mw_ready),
    .o_busy_cnt(o_busy_cnt)
  );

  typedef struct packed {
    logic        v;
    logic [5:0]  idx;
    logic [19:0] tag;
    logic [3:0]  prdy, srdy, vld;
    logic [23:0] midx;
    logic [79:0] mtag;
    logic        e_nack;
    logic [3:0]  e_pri, e_sec;
    logic [1:0]  e_id;
    logic        e_chk_id;
  } vec_t;

  typedef struct {
    int         id;
    logic       e_nack;
    logic [3:0] e_pri, e_sec;
    logic [1:0] e_id;
    logic       e_chk_id;
  } exp_t;

  exp_t sb_q[$];
  vec_t vecs[9];

  function automatic vec_t mkv(logic v, logic [5:0] idx, logic [19:0] tag,
                               logic [3:0] prdy, logic [3:0] srdy, logic [3:0] vld,
                               logic [23:0] midx, logic [79:0] mtag,
                               logic en, logic [3:0] ep, logic [3:0] es,
                               logic [1:0] eid, logic ec);
    vec_t r;
    r.v = v; r.idx = idx; r.tag = tag; r.prdy = prdy; r.srdy = srdy; r.vld = vld;
    r.midx = midx; r.mtag = mtag; r.e_nack = en; r.e_pri = ep; r.e_sec = es;
    r.e_id = eid; r.e_chk_id = ec;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive_req(input logic v, input logic [5:0] idx, input logic [19:0] tag,
                           input logic [3:0] prdy, input logic [3:0] srdy,
                           input logic [3:0] vld, input logic [23:0] midx,
                           input logic [79:0] mtag);
    @(posedge clock);
    #1;
    i_req_valid = v; i_req_idx = idx; i_req_tag = tag;
    i_pri_rdy = prdy; i_sec_rdy = srdy; i_mshr_vld = vld;
    i_mshr_idx = midx; i_mshr_tag = mtag;
  endtask

  task automatic expect_req(input int id, input logic en, input logic [3:0] ep,
                            input logic [3:0] es, input logic [1:0] eid, input logic ec);
    exp_t e;
    e.id = id; e.e_nack = en; e.e_pri = ep; e.e_sec = es; e.e_id = eid; e.e_chk_id = ec;
    sb_q.push_back(e);
  endtask

  task automatic check_req();
    exp_t e;
    @(negedge clock);
    if (sb_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard: empty queue at check");
    end else begin
      e = sb_q.pop_front();
      chk($sformatf("req%0d ready", e.id), 32'(o_req_ready), 32'd1);
      chk($sformatf("req%0d nack", e.id), 32'(o_nack), 32'(e.e_nack));
      chk($sformatf("req%0d pri", e.id), 32'(o_pri_val), 32'(e.e_pri));
      chk($sformatf("req%0d sec", e.id), 32'(o_sec_val), 32'(e.e_sec));
      if (e.e_chk_id) begin
        chk($sformatf("req%0d id", e.id), 32'(o_alloc_id), 32'(e.e_id));
      end
    end
  endtask

  task automatic idle(input logic [3:0] vld);
    drive_req(1'b0, 6'd0, 20'h0, 4'b1111, 4'b1111, vld, 24'd0, 80'd0);
  endtask

  task automatic mw_step(input string name, input logic [3:0] r, input logic rd,
                         input logic [3:0] eg);
    @(posedge clock);
    #1;
    i_mw_req = r;
    i_mw_ready = rd;
    @(negedge clock);
    chk(name, 32'(o_mw_grant), 32'(eg));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // Reset with every request line active: nothing may escape.
    reset = 1'b0;
    i_req_valid = 1'b1; i_req_idx = 6'd5; i_req_tag = 20'h100;
    i_pri_rdy = 4'b1111; i_sec_rdy = 4'b1111; i_mshr_vld = 4'b1111;
    i_mshr_idx = 24'd0; i_mshr_tag = 80'd0;
    i_mw_req = 4'b1111; i_mw_ready = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("rst grant", 32'(o_mw_grant), 32'd0);
    chk("rst pri", 32'(o_pri_val), 32'd0);
    chk("rst sec", 32'(o_sec_val), 32'd0);
    chk("rst busy", 32'(o_busy_cnt), 32'd0);
    @(posedge clock);
    #1;
    reset = 1'b1;
    @(negedge clock);
    chk("post-rst grant", 32'(o_mw_grant), 32'd0);
    chk("post-rst pri", 32'(o_pri_val), 32'd0);

    // Primary on idle bank, then same line next cycle merges via shadow.
    drive_req(1'b1, 6'd5, 20'h100, 4'b1111, 4'b1111, 4'b0000, 24'd0, 80'd0);
    i_mw_req = 4'b0000;
    expect_req(100, 1'b0, 4'b0001, 4'b0000, 2'd0, 1'b1);
    check_req();
    chk("busy after rst", 32'(o_busy_cnt), 32'd4);
    drive_req(1'b1, 6'd5, 20'h100, 4'b1111, 4'b0001, 4'b0000, 24'd0, 80'd0);
    expect_req(101, 1'b0, 4'b0000, 4'b0001, 2'd0, 1'b1);
    check_req();
    idle(4'b0000);

    // Table; rr_alloc is 1 here. Each vector is followed by an idle cycle.
    vecs[0] = mkv(1'b1, 6'd5, 20'h100, 4'b1101, 4'b1111, 4'b0010,
                  {6'd0, 6'd0, 6'd5, 6'd0}, {20'h0, 20'h0, 20'h100, 20'h0},
                  1'b1, 4'b0000, 4'b0000, 2'd0, 1'b0);
    vecs[0].tag = 20'h200;
    vecs[1] = mkv(1'b1, 6'd7, 20'h3, 4'b1111, 4'b1011, 4'b0100,
                  {6'd0, 6'd7, 6'd0, 6'd0}, {20'h0, 20'h3, 20'h0, 20'h0},
                  1'b1, 4'b0000, 4'b0000, 2'd0, 1'b0);
    vecs[2] = mkv(1'b1, 6'd7, 20'h3, 4'b1111, 4'b1111, 4'b0100,
                  {6'd0, 6'd7, 6'd0, 6'd0}, {20'h0, 20'h3, 20'h0, 20'h0},
                  1'b0, 4'b0000, 4'b0100, 2'd2, 1'b1);
    vecs[3] = mkv(1'b1, 6'd9, 20'h1, 4'b0000, 4'b1111, 4'b0000, 24'd0, 80'd0,
                  1'b1, 4'b0000, 4'b0000, 2'd0, 1'b0);
    vecs[4] = mkv(1'b1, 6'd9, 20'h1, 4'b1111, 4'b1111, 4'b0000, 24'd0, 80'd0,
                  1'b0, 4'b0010, 4'b0000, 2'd1, 1'b1);
    vecs[5] = mkv(1'b1, 6'd10, 20'h2, 4'b0011, 4'b1111, 4'b0000, 24'd0, 80'd0,
                  1'b0, 4'b0001, 4'b0000, 2'd0, 1'b1);
    vecs[6] = mkv(1'b1, 6'd3, 20'hB, 4'b1111, 4'b1111, 4'b1001,
                  {6'd3, 6'd0, 6'd0, 6'd3}, {20'hB, 20'h0, 20'h0, 20'hA},
                  1'b0, 4'b0000, 4'b1000, 2'd3, 1'b1);
    vecs[7] = mkv(1'b1, 6'd8, 20'hA, 4'b1101, 4'b1111, 4'b0010,
                  {6'd0, 6'd0, 6'd4, 6'd0}, {20'h0, 20'h0, 20'hA, 20'h0},
                  1'b0, 4'b0100, 4'b0000, 2'd2, 1'b1);
    vecs[8] = mkv(1'b0, 6'd8, 20'hA, 4'b1111, 4'b1111, 4'b0000, 24'd0, 80'd0,
                  1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0);
    for (int i = 0; i < 9; i++) begin
      drive_req(vecs[i].v, vecs[i].idx, vecs[i].tag, vecs[i].prdy, vecs[i].srdy,
                vecs[i].vld, vecs[i].midx, vecs[i].mtag);
      expect_req(i, vecs[i].e_nack, vecs[i].e_pri, vecs[i].e_sec, vecs[i].e_id, vecs[i].e_chk_id);
      check_req();
      idle(4'b0000);
    end

    // rr_alloc is 3: three new lines back to back wrap to ids 3, 0, 1.
    for (int i = 0; i < 3; i++) begin
      logic [3:0] ep;
      logic [1:0] eid;
      eid = 2'(i + 3);
      ep = 4'b0001 << eid;
      drive_req(1'b1, 6'(11 + i), 20'(i + 1), 4'b1111, 4'b1111, 4'b0000, 24'd0, 80'd0);
      expect_req(200 + i, 1'b0, ep, 4'b0000, eid, 1'b1);
      check_req();
    end

    // Occupancy count is registered.
    idle(4'b1011);
    idle(4'b1011);
    @(negedge clock);
    chk("busy 1011", 32'(o_busy_cnt), 32'd3);

    // Meta-write: lock on 1 while not ready, then rotate to 3.
    mw_step("mw lock c1", 4'b1010, 1'b0, 4'b0010);
    mw_step("mw lock c2", 4'b1010, 1'b0, 4'b0010);
    mw_step("mw lock c3", 4'b1010, 1'b0, 4'b0010);
    mw_step("mw done", 4'b1010, 1'b1, 4'b0010);
    mw_step("mw next", 4'b1010, 1'b1, 4'b1000);
    mw_step("mw solo", 4'b0010, 1'b1, 4'b0010);
    i_mshr_vld = 4'b1111;
    mw_step("mw lock2", 4'b1010, 1'b0, 4'b1000);

    // Reset in the middle of the lock.
    @(posedge clock);
    #1;
    reset = 1'b0;
    @(negedge clock);
    chk("midrst grant", 32'(o_mw_grant), 32'd0);
    @(negedge clock);
    chk("midrst grant2", 32'(o_mw_grant), 32'd0);
    chk("midrst busy", 32'(o_busy_cnt), 32'd0);
    @(posedge clock);
    #1;
    reset = 1'b1;
    @(negedge clock);
    chk("midrst post grant", 32'(o_mw_grant), 32'd0);
    drive_req(1'b1, 6'd20, 20'h5, 4'b1111, 4'b1111, 4'b0000, 24'd0, 80'd0);
    i_mw_req = 4'b1010;
    i_mw_ready = 1'b1;
    expect_req(300, 1'b0, 4'b0001, 4'b0000, 2'd0, 1'b1);
    check_req();
    chk("midrst rr_mw", 32'(o_mw_grant), 32'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
